// File: rtl/irrigation_pkg.sv
// Shared code values, segment patterns and scan FSM states for the irrigation display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package irrigation_pkg;

  localparam logic [1:0] IRR_BLANK     = 2'b00;
  localparam logic [1:0] IRR_SPRINKLER = 2'b01;
  localparam logic [1:0] IRR_DRIP      = 2'b10;
  localparam logic [1:0] IRR_NOAUTH    = 2'b11;

  localparam logic [6:0] SEG_BLANK     = 7'h00;
  localparam logic [6:0] SEG_SPRINKLER = 7'h77;  // 'A'
  localparam logic [6:0] SEG_DRIP      = 7'h3D;  // 'G'
  localparam logic [6:0] SEG_NOAUTH    = 7'h40;  // '-'

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/irrigation_seg_rom.sv
// Combinational 2-bit irrigation code to active-high 7-segment pattern lookup.
// No latency; no flow control.
module irrigation_seg_rom
  import irrigation_pkg::*;
(
  input  logic [1:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      IRR_BLANK:     o_seg = SEG_BLANK;
      IRR_SPRINKLER: o_seg = SEG_SPRINKLER;
      IRR_DRIP:      o_seg = SEG_DRIP;
      IRR_NOAUTH:    o_seg = SEG_NOAUTH;
      default:       o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/irrigation_display_scanner.sv
// Time-multiplexes N_ZONES irrigation codes onto one 7-segment bus with anti-ghost blanking.
// Optional blinking of no-auth zones is enabled by defining IRRIG_BLINK_EN.
module irrigation_display_scanner
  import irrigation_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GHOST_CYC  = 2,
  parameter int BLINK_DIV  = 25,
  parameter int ACTIVE_LOW = 1
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [2*N_ZONES-1:0] mode_i,
  output logic [6:0]           seg_o,
  output logic [N_ZONES-1:0]   digit_o,
  output logic                 frame_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_LAST = CNT_W'(GHOST_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_ZONES - 1);
  localparam logic             POL        = (ACTIVE_LOW != 0);

  if (N_ZONES < 1 || N_ZONES > 8) begin : g_chk_zones
    $error("N_ZONES must be 1..8");
  end
  if (GHOST_CYC < 1 || SCAN_DIV < GHOST_CYC + 1) begin : g_chk_scan
    $error("need GHOST_CYC >= 1 and SCAN_DIV >= GHOST_CYC+1");
  end
  if (BLINK_DIV < 1) begin : g_chk_blink
    $error("BLINK_DIV must be >= 1");
  end

  scan_state_t          r_state;
  scan_state_t          w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_frame_start;
  logic [2*N_ZONES-1:0] r_shadow;
  logic [1:0]           w_code;
  logic [6:0]           w_rom_seg;
  logic [6:0]           w_seg_disp;
  logic [6:0]           w_seg_act;
  logic [N_ZONES-1:0]   w_digit_act;
  logic [6:0]           r_seg;
  logic [N_ZONES-1:0]   r_digit;
  logic                 r_frame;

  // Next-state logic; en_i low overrides every state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_frame_start = 1'b0;
    if (!en_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_BLANK;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_frame_start = 1'b1;
        end
        ST_BLANK: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == GHOST_LAST) begin
            w_state_nxt = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt     = '0;
              w_frame_start = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_frame_start) begin
        r_shadow <= mode_i;
      end
    end
  end

  // Entering DRIVE never changes idx or shadow, so the current shadow[idx] is the digit being lit.
  assign w_code = r_shadow[{r_idx, 1'b0} +: 2];

  irrigation_seg_rom u_seg_rom (
    .i_code (w_code),
    .o_seg  (w_rom_seg)
  );

`ifdef IRRIG_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic               r_blink_hide;

  // Hide flag is latched per frame from the phase before this frame's advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_blink_hide  <= 1'b0;
    end else if (w_frame_start) begin
      r_blink_hide <= r_blink_phase;
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_seg_disp = (r_blink_hide && (w_code == IRR_NOAUTH)) ? SEG_BLANK : w_rom_seg;
`else
  assign w_seg_disp = w_rom_seg;
`endif

  always_comb begin
    w_digit_act = '0;
    w_seg_act   = SEG_BLANK;
    if (w_state_nxt == ST_DRIVE) begin
      for (int z = 0; z < N_ZONES; z++) begin
        w_digit_act[z] = (w_idx_nxt == IDX_W'(z));
      end
      w_seg_act = w_seg_disp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= {7{POL}};
      r_digit <= {N_ZONES{POL}};
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_act ^ {7{POL}};
      r_digit <= w_digit_act ^ {N_ZONES{POL}};
      r_frame <= w_frame_start;
    end
  end

  assign seg_o   = r_seg;
  assign digit_o = r_digit;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_irrigation_display_scanner.sv
// Bench for irrigation_display_scanner: frame-position reference model, vector table and corner sequences.
// An active-low instance runs in parallel and must always show the inverse of the active-high outputs.
module tb_irrigation_display_scanner;

  localparam int NZ = 4;
  localparam int SD = 8;
  localparam int GC = 2;
  localparam int BD = 2;
  localparam int FL = NZ * SD;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       en_i   = 1'b0;
  logic [7:0] mode_i = 8'h00;

  logic [6:0] seg, seg_al;
  logic [3:0] dig, dig_al;
  logic       frm, frm_al;

  int checks = 0;
  int errors = 0;

  irrigation_display_scanner #(
    .N_ZONES(NZ), .SCAN_DIV(SD), .GHOST_CYC(GC), .BLINK_DIV(BD), .ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i),
    .seg_o(seg), .digit_o(dig), .frame_o(frm)
  );

  irrigation_display_scanner #(
    .N_ZONES(NZ), .SCAN_DIV(SD), .GHOST_CYC(GC), .BLINK_DIV(BD), .ACTIVE_LOW(1)
  ) u_dut_al (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i),
    .seg_o(seg_al), .digit_o(dig_al), .frame_o(frm_al)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame since the enabling edge.
  bit         m_en;
  int         m_t;
  logic [7:0] m_shadow;
  int         m_frames;
  bit         m_hide;

  typedef struct {
    logic [7:0]      mode;
    logic [3:0][6:0] exp_seg;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input logic [1:0] c, input bit hide);
    case (c)
      2'b01:   return 7'h77;
      2'b10:   return 7'h3D;
      2'b11:   return hide ? 7'h00 : 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_en     = 0;
    m_t      = 0;
    m_shadow = 8'h00;
    m_frames = 0;
    m_hide   = 0;
  endtask

  task automatic step();
    int         p, slot;
    logic [6:0] e_seg, e_seg_n;
    logic [3:0] e_dig, e_dig_n;
    logic       e_frm;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (!en_i) begin
      m_en = 0;
    end else begin
      if (!m_en) begin
        m_en = 1;
        m_t  = 0;
      end else begin
        m_t++;
      end
      if (m_t % FL == 0) begin
        m_shadow = mode_i;
`ifdef IRRIG_BLINK_EN
        m_hide = ((m_frames / BD) % 2) == 1;
`else
        m_hide = 0;
`endif
        m_frames++;
      end
    end
    #1;
    e_seg = 7'h00;
    e_dig = 4'h0;
    e_frm = 1'b0;
    if (m_en) begin
      p     = m_t % FL;
      slot  = p / SD;
      e_frm = (p == 0);
      if ((p % SD) >= GC) begin
        e_dig = 4'(1 << slot);
        e_seg = pat(m_shadow[2*slot +: 2], m_hide);
      end
    end
    e_seg_n = ~e_seg;
    e_dig_n = ~e_dig;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("digit", 32'(dig), 32'(e_dig));
    chk("frame", 32'(frm), 32'(e_frm));
    chk("al_seg", 32'(seg_al), 32'(e_seg_n));
    chk("al_digit", 32'(dig_al), 32'(e_dig_n));
    chk("al_frame", 32'(frm_al), 32'(e_frm));
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_digit", 32'(dig), 32'h0);
    chk("rst_frame", 32'(frm), 32'h0);
    chk("rst_al_seg", 32'(seg_al), 32'h7F);
    chk("rst_al_digit", 32'(dig_al), 32'hF);
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (!(m_en && m_t == target) && n < 500) begin
      step();
      n++;
    end
    if (!(m_en && m_t == target)) begin
      checks++;
      errors++;
      $display("FAIL run_to_timeout actual=%0d required=%0d", m_t, target);
    end
  endtask

  logic [3:0][6:0] blink_exp;

  initial begin
    tbl[0].mode = 8'b11_10_01_00; tbl[0].exp_seg = {7'h40, 7'h3D, 7'h77, 7'h00};
    tbl[1].mode = 8'h55;          tbl[1].exp_seg = {7'h77, 7'h77, 7'h77, 7'h77};
    tbl[2].mode = 8'hAA;          tbl[2].exp_seg = {7'h3D, 7'h3D, 7'h3D, 7'h3D};
    tbl[3].mode = 8'b00_01_10_11; tbl[3].exp_seg = {7'h00, 7'h77, 7'h3D, 7'h40};

    model_reset();
    #1;
    do_reset();
    step();
    step();

    // Enable latency, zone 0 timing and the async reset landing mid-DRIVE.
    mode_i = tbl[0].mode;
    en_i   = 1'b1;
    step();
    chk("first_frame", 32'(frm), 32'h1);
    chk("first_digit_blank", 32'(dig), 32'h0);
    step();
    chk("ghost_digit", 32'(dig), 32'h0);
    step();
    chk("first_lit", 32'(dig), 32'h1);
    run_to(4);
    do_reset();
    step();
    chk("idle_after_rst", 32'(dig), 32'h0);

    // Mid-frame mode change only shows from the next frame.
    step();
    run_to(10);
    mode_i = 8'h55;
    run_to(20);
    chk("old_frame_zone2", 32'(seg), 32'h3D);
    run_to(FL + 12);
    chk("new_frame_zone1", 32'(seg), 32'h77);
    run_to(FL + 28);
    chk("new_frame_zone3", 32'(seg), 32'h77);

    // Disable mid-frame, then restart at zone 0.
    do_reset();
    mode_i = tbl[0].mode;
    en_i   = 1'b1;
    run_to(12);
    en_i = 1'b0;
    step();
    chk("dis_seg", 32'(seg), 32'h0);
    chk("dis_digit", 32'(dig), 32'h0);
    step();
    en_i = 1'b1;
    step();
    chk("reen_frame", 32'(frm), 32'h1);
    step();
    step();
    chk("reen_zone0", 32'(dig), 32'h1);

    // No-auth blinking over four frames.
`ifdef IRRIG_BLINK_EN
    blink_exp = {7'h00, 7'h00, 7'h40, 7'h40};
`else
    blink_exp = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
    do_reset();
    mode_i = 8'b11_00_00_00;
    en_i   = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_to(f * FL + 3 * SD + 4);
      chk("blink_zone3", 32'(seg), 32'(blink_exp[f]));
    end

    // Vector table: one frame per pattern, checked mid-slot per zone.
    for (int i = 0; i < 4; i++) begin
      logic [6:0] inv;
      do_reset();
      mode_i = tbl[i].mode;
      en_i   = 1'b1;
      for (int z = 0; z < NZ; z++) begin
        run_to(z * SD + 4);
        inv = ~tbl[i].exp_seg[z];
        chk("tbl_seg", 32'(seg), 32'(tbl[i].exp_seg[z]));
        chk("tbl_digit", 32'(dig), 32'(1 << z));
        chk("tbl_al_seg", 32'(seg_al), 32'(inv));
      end
    end

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en_i = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 15) == 0) mode_i = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
